// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle for the wb_timer responder.
// Signal names keep the responder's point of view (_i into the timer, _o out of it).
interface wb_timer_if #(
    parameter int unsigned TAGSIZE = 1
) ();
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic               wb_we_i;
    logic [31:0]        wb_adr_i;
    logic [31:0]        wb_dat_i;
    logic [3:0]         wb_sel_i;
    logic [TAGSIZE-1:0] wb_tgd_i;
    logic [31:0]        wb_dat_o;
    logic [TAGSIZE-1:0] wb_tgd_o;
    logic               wb_ack_o;
    logic               wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_tgd_i,
        output wb_dat_o, wb_tgd_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_tgd_i,
        input  wb_dat_o, wb_tgd_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_timer.sv
// Wishbone classic timer peripheral: 32-bit counter behind a 16-bit prescaler,
// compare match with optional auto-reload, and a level interrupt.
// Map: 0x00 CTRL, 0x04 PRESCALE, 0x08 COUNT, 0x0C COMPARE, 0x10 STATUS (W1C).
module wb_timer #(
    parameter int unsigned TAGSIZE   = 1,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic      clk,
    input  logic      rstn_i,
    wb_timer_if.slave wb,
    output logic      irq_o
);
    localparam int unsigned IdxW = ADDR_BITS - 2;

    // Register state
    logic               en_q, en_d;
    logic               irq_en_q, irq_en_d;
    logic               auto_q, auto_d;
    logic [15:0]        prescale_q, prescale_d;
    logic [15:0]        pcnt_q, pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic               match_q, match_d;

    // Bus response state
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        dat_q, dat_d;
    logic [TAGSIZE-1:0] tgd_q, tgd_d;
    logic               irq_q, irq_d;

    logic               req;
    logic               hit;
    logic               wr_en;
    logic               tick;
    logic               cmp_hit;
    logic [IdxW-1:0]    idx;
    logic [31:0]        rdata;
    logic               unused_adr;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    assign idx        = wb.wb_adr_i[ADDR_BITS-1:2];
    assign unused_adr = ^{wb.wb_adr_i[31:ADDR_BITS], wb.wb_adr_i[1:0]};

    // The !ack/!err term keeps a held strobe from being taken twice in a row.
    assign req   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign wr_en = req & wb.wb_we_i & hit;

    // Address decode and read mux
    always_comb begin
        hit   = 1'b1;
        rdata = '0;
        case (idx)
            IdxW'(0): rdata = {29'b0, auto_q, irq_en_q, en_q};
            IdxW'(1): rdata = {16'b0, prescale_q};
            IdxW'(2): rdata = count_q;
            IdxW'(3): rdata = compare_q;
            IdxW'(4): rdata = {31'b0, match_q};
            default:  hit = 1'b0;
        endcase
    end

    assign tick    = en_q & (pcnt_q == prescale_q);
    assign cmp_hit = count_q == compare_q;

    // Next state: timer progress first, then bus writes override it
    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        auto_d     = auto_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        match_d    = match_q;

        // pcnt is not reset by a PRESCALE write; it may wrap through 0xFFFF.
        if (!en_q) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        if (tick) begin
            if (cmp_hit && auto_q) begin
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (idx)
                IdxW'(0): begin
                    if (wb.wb_sel_i[0]) begin
                        {auto_d, irq_en_d, en_d} = wb.wb_dat_i[2:0];
                    end
                end
                IdxW'(1): begin
                    if (wb.wb_sel_i[0]) prescale_d[7:0]  = wb.wb_dat_i[7:0];
                    if (wb.wb_sel_i[1]) prescale_d[15:8] = wb.wb_dat_i[15:8];
                end
                IdxW'(2): count_d   = byte_merge(count_q, wb.wb_dat_i, wb.wb_sel_i);
                IdxW'(3): compare_d = byte_merge(compare_q, wb.wb_dat_i, wb.wb_sel_i);
                IdxW'(4): begin
                    if (wb.wb_sel_i[0] && wb.wb_dat_i[0]) match_d = 1'b0;
                end
                default: ;
            endcase
        end

        // A new match beats a same-cycle clear.
        if (tick && cmp_hit) match_d = 1'b1;
    end

    // Response and interrupt next state
    always_comb begin
        ack_d = req & hit;
        err_d = req & ~hit;
        dat_d = (req & hit & ~wb.wb_we_i) ? rdata : 32'h0;
        tgd_d = req ? wb.wb_tgd_i : '0;
        irq_d = match_d & irq_en_d;
    end

    // All state flops, cleared asynchronously
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            auto_q     <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            tgd_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            auto_q     <= auto_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            tgd_q      <= tgd_d;
            irq_q      <= irq_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_tgd_o = tgd_q;
    assign irq_o       = irq_q;
endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register access, prescaler timing, match/irq,
// wrap, byte enables, bus errors, held strobe, tags and reset mid-access.
module tb_wb_timer;
    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_PRE  = 32'h04;
    localparam logic [31:0] A_CNT  = 32'h08;
    localparam logic [31:0] A_CMP  = 32'h0C;
    localparam logic [31:0] A_STAT = 32'h10;

    logic clk = 1'b0;
    logic rstn_i = 1'b1;
    logic irq_o;

    wb_timer_if #(.TAGSIZE(1)) bus ();

    wb_timer #(
        .TAGSIZE  (1),
        .ADDR_BITS(5)
    ) dut (
        .clk   (clk),
        .rstn_i(rstn_i),
        .wb    (bus),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        r_ack, r_err, r_tgd, r_irq;
    logic [31:0] r_dat;

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;
        bus.wb_tgd_i = 1'b0;
    endtask

    // Request is taken on the next posedge; response sampled at the following negedge.
    task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, input logic tgd);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = wdat;
        bus.wb_sel_i = sel;
        bus.wb_tgd_i = tgd;
        @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        r_ack = bus.wb_ack_o;
        r_err = bus.wb_err_o;
        r_dat = bus.wb_dat_o;
        r_tgd = bus.wb_tgd_o;
        r_irq = irq_o;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
        access(1'b1, adr, wdat, sel, 1'b0);
    endtask

    task automatic rd(input logic [31:0] adr, input logic tgd);
        access(1'b0, adr, 32'h0, 4'h0, tgd);
    endtask

    task automatic test_reset();
        bus_idle();
        #1 rstn_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.wb_ack_o, bus.wb_err_o, irq_o, bus.wb_tgd_o, bus.wb_dat_o} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b err=%b irq=%b tgd=%b dat=%h want all 0",
                     bus.wb_ack_o, bus.wb_err_o, irq_o, bus.wb_tgd_o, bus.wb_dat_o);
        end
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd(32'(i * 4), 1'b0);
            checks++;
            if ({r_ack, r_err, r_irq, r_tgd} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_rd_hs[%0d]: got ack=%b err=%b irq=%b tgd=%b want 1 0 0 0",
                         i, r_ack, r_err, r_irq, r_tgd);
            end
            checks++;
            if (r_dat !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd_dat[%0d]: got %h want %h", i, r_dat, 32'h0);
            end
        end
    endtask

    task automatic test_tag();
        rd(A_CTRL, 1'b1);
        checks++;
        if ({r_ack, r_tgd} !== 2'b11) begin
            errors++;
            $display("FAIL tag_return: got ack=%b tgd=%b want ack=1 tgd=1", r_ack, r_tgd);
        end
    endtask

    // PRESCALE=3: ticks every 4 cycles; COUNT after k cycles of EN is floor(k/4).
    task automatic test_prescale();
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        repeat (40) @(negedge clk);
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'd10) begin
            errors++;
            $display("FAIL prescale_cnt_a: got %0d want %0d", r_dat, 10);
        end
        checks++;
        if (r_irq !== 1'b0) begin
            errors++;
            $display("FAIL prescale_irq_masked: got %b want %b", r_irq, 1'b0);
        end
        repeat (2) @(negedge clk);
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'd11) begin
            errors++;
            $display("FAIL prescale_cnt_b: got %0d want %0d", r_dat, 11);
        end
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'd11) begin
            errors++;
            $display("FAIL prescale_cnt_c: got %0d want %0d", r_dat, 11);
        end
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'd12) begin
            errors++;
            $display("FAIL prescale_cnt_d: got %0d want %0d", r_dat, 12);
        end
        wr(A_CTRL, 32'h0, 4'hF);
    endtask

    // COMPARE=5, PRESCALE=0, auto-reload: match period is 6 cycles after enable.
    task automatic test_match();
        wr(A_STAT, 32'h1, 4'hF);
        wr(A_CMP, 32'd5, 4'hF);
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'h7, 4'hF);
        repeat (5) @(negedge clk);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL match_irq_pre: got %b want %b", irq_o, 1'b0);
        end
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'd0) begin
            errors++;
            $display("FAIL match_reload_cnt: got %0d want %0d", r_dat, 0);
        end
        checks++;
        if (r_irq !== 1'b1) begin
            errors++;
            $display("FAIL match_irq_rise: got %b want %b", r_irq, 1'b1);
        end
        rd(A_STAT, 1'b0);
        checks++;
        if (r_dat !== 32'h1) begin
            errors++;
            $display("FAIL match_status: got %h want %h", r_dat, 32'h1);
        end
        wr(A_STAT, 32'h1, 4'hF);
        checks++;
        if (r_irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_irq_fall: got %b want %b", r_irq, 1'b0);
        end
        wr(A_STAT, 32'h1, 4'hF);
        checks++;
        if (r_irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_irq_fall2: got %b want %b", r_irq, 1'b0);
        end
        repeat (3) @(negedge clk);
        wr(A_STAT, 32'h1, 4'hF);
        checks++;
        if (r_irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_vs_set: got %b want %b", r_irq, 1'b1);
        end
        wr(A_CTRL, 32'h0, 4'hF);
        checks++;
        if (r_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_en_mask: got %b want %b", r_irq, 1'b0);
        end
        rd(A_STAT, 1'b0);
        checks++;
        if (r_dat !== 32'h1) begin
            errors++;
            $display("FAIL mask_keeps_match: got %h want %h", r_dat, 32'h1);
        end
    endtask

    // PRESCALE=1: ticks every 2nd cycle from 0xFFFFFFFE through the wrap.
    task automatic test_wrap();
        wr(A_PRE, 32'd1, 4'hF);
        wr(A_STAT, 32'h1, 4'hF);
        wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
        wr(A_CMP, 32'h0, 4'hF);
        wr(A_CTRL, 32'h3, 4'hF);
        repeat (2) @(negedge clk);
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_max: got %h want %h", r_dat, 32'hFFFF_FFFF);
        end
        checks++;
        if (r_irq !== 1'b0) begin
            errors++;
            $display("FAIL wrap_no_match: got %b want %b", r_irq, 1'b0);
        end
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: got %h want %h", r_dat, 32'h0);
        end
        checks++;
        if (r_irq !== 1'b1) begin
            errors++;
            $display("FAIL wrap_match_irq: got %b want %b", r_irq, 1'b1);
        end
        rd(A_STAT, 1'b0);
        checks++;
        if (r_dat !== 32'h1) begin
            errors++;
            $display("FAIL wrap_status: got %h want %h", r_dat, 32'h1);
        end
        // This write lands on a tick edge; the written value must survive.
        wr(A_CNT, 32'h100, 4'hF);
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'h100) begin
            errors++;
            $display("FAIL count_write_vs_tick: got %h want %h", r_dat, 32'h100);
        end
        wr(A_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_sel_err();
        wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
        rd(A_CTRL, 1'b0);
        checks++;
        if (r_dat !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_mask: got %h want %h", r_dat, 32'h0);
        end
        wr(A_PRE, 32'hFFFF_1234, 4'hF);
        rd(A_PRE, 1'b0);
        checks++;
        if (r_dat !== 32'h0000_1234) begin
            errors++;
            $display("FAIL prescale_mask: got %h want %h", r_dat, 32'h0000_1234);
        end
        wr(A_CMP, 32'h0, 4'hF);
        wr(A_CMP, 32'hAABB_CCDD, 4'b0101);
        rd(A_CMP, 1'b0);
        checks++;
        if (r_dat !== 32'h00BB_00DD) begin
            errors++;
            $display("FAIL sel_0101: got %h want %h", r_dat, 32'h00BB_00DD);
        end
        wr(A_CMP, 32'hFFFF_FFFF, 4'h0);
        checks++;
        if ({r_ack, r_err} !== 2'b10) begin
            errors++;
            $display("FAIL sel0_ack: got ack=%b err=%b want 1 0", r_ack, r_err);
        end
        rd(A_CMP, 1'b0);
        checks++;
        if (r_dat !== 32'h00BB_00DD) begin
            errors++;
            $display("FAIL sel0_nochange: got %h want %h", r_dat, 32'h00BB_00DD);
        end
        wr(A_CNT, 32'h55, 4'hF);
        wr(32'h18, 32'h1234_5678, 4'hF);
        checks++;
        if ({r_ack, r_err} !== 2'b01) begin
            errors++;
            $display("FAIL err_wr_18: got ack=%b err=%b want 0 1", r_ack, r_err);
        end
        rd(A_CNT, 1'b0);
        checks++;
        if (r_dat !== 32'h55) begin
            errors++;
            $display("FAIL err_no_effect: got %h want %h", r_dat, 32'h55);
        end
        rd(32'h1C, 1'b0);
        checks++;
        if ({r_ack, r_err, r_dat} !== {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL err_rd_1c: got ack=%b err=%b dat=%h want 0 1 0", r_ack, r_err, r_dat);
        end
    endtask

    task automatic test_back_to_back();
        int n_ack;
        int n_err;
        n_ack = 0;
        n_err = 0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = A_PRE;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            if (i == 5) begin
                #1;
                bus_idle();
            end
            @(negedge clk);
            if (bus.wb_ack_o === 1'b1) n_ack++;
            if (bus.wb_err_o === 1'b1) n_err++;
        end
        @(negedge clk);
        if (bus.wb_ack_o === 1'b1) n_ack++;
        checks++;
        if (n_ack != 3 || n_err != 0) begin
            errors++;
            $display("FAIL held_stb_acks: got ack=%0d err=%0d want ack=3 err=0", n_ack, n_err);
        end
    endtask

    task automatic test_reset_mid();
        wr(A_CTRL, 32'h6, 4'hF);
        wr(A_PRE, 32'h7, 4'hF);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = A_CNT;
        @(posedge clk);
        #1;
        bus_idle();
        #1 rstn_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_ack: got ack=%b err=%b want 0 0",
                     bus.wb_ack_o, bus.wb_err_o);
        end
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd(32'(i * 4), 1'b0);
            checks++;
            if ({r_ack, r_dat} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL rst_mid_rd[%0d]: got ack=%b dat=%h want 1 0", i, r_ack, r_dat);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tag();
        test_prescale();
        test_match();
        test_wrap();
        test_sel_err();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone classic responder (slave) timer peripheral; sits on a slave port of wishbone_interconnect beside the instruction/data RAM.
- Gives the core a free-running 32-bit counter with a 16-bit prescaler, a compare match, auto-reload and a level interrupt.
- Registers are memory-mapped, word-aligned and 32 bits wide.
- Unmapped offsets return a bus error.

Parameters:
- TAGSIZE, 1, width of the wishbone tag (tgd) lines; tags are passed through unchanged.
- ADDR_BITS, 5, number of low address bits decoded (32-byte window).

Ports:
- clk, input, 1, system clock.
- rstn_i, input, 1, reset (asynchronous, active-low).
- wb_cyc_i, input, 1, bus cycle valid.
- wb_stb_i, input, 1, strobe.
- wb_we_i, input, 1, 1 = write.
- wb_adr_i, input, 32, byte address; only bits [ADDR_BITS-1:2] are decoded.
- wb_dat_i, input, 32, write data.
- wb_sel_i, input, 4, byte enables for writes.
- wb_tgd_i, input, TAGSIZE, request tag.
- wb_dat_o, output, 32, read data.
- wb_tgd_o, output, TAGSIZE, response tag, captured with the request.
- wb_ack_o, output, 1, access done.
- wb_err_o, output, 1, access rejected.
- irq_o, output, 1, timer interrupt (level).

Behaviour:
- Reset: all registers, prescale counter, wb_ack_o, wb_err_o, wb_dat_o, wb_tgd_o and irq_o are 0.
- Reset asserted mid-access drops any pending ack/err immediately.

Register map (offset, field):
- 0x00 CTRL, RW: [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD; all other bits read 0.
- 0x04 PRESCALE, RW: [15:0]; upper bits read 0.
- 0x08 COUNT, RW: [31:0].
- 0x0C COMPARE, RW: [31:0].
- 0x10 STATUS: [0] MATCH; write 1 to clear, writing 0 has no effect.
- 0x14 to 0x1C: unmapped.

Bus handshake:
- A request is wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o.
- The response comes exactly 1 cycle later as a single-cycle pulse on wb_ack_o, or on wb_err_o for an unmapped offset.
- Because of the !ack/!err term, a master holding stb gets a new response at most every 2nd cycle.
- wb_dat_o and wb_tgd_o are registered with the response and are valid only while ack is high.
- Write side effects occur on the request cycle.
- Writes honour wb_sel_i per byte; sel = 0 still acks with no change.
- An unmapped write changes nothing.
- Reads ignore wb_sel_i.
- Dropping cyc between the request and its response does not cancel the pending response.

Prescaler and tick:
- While EN = 1, the 16-bit prescale counter (pcnt) counts 0..PRESCALE.
- A tick fires on the cycle pcnt == PRESCALE, and pcnt returns to 0.
- PRESCALE = 0 gives a tick every cycle.
- While EN = 0, pcnt is held at 0 and there are no ticks.
- Writing PRESCALE does not reset pcnt. If pcnt > new PRESCALE, pcnt wraps through 0xFFFF before the next tick.

Counter on a tick:
- If COUNT == COMPARE: MATCH is set; COUNT becomes 0 if AUTO_RELOAD = 1, otherwise COUNT+1.
- Otherwise COUNT becomes COUNT+1, modulo 2^32 (0xFFFFFFFF wraps to 0, no flag).

Simultaneous events:
- A bus write to COUNT in the same cycle as a tick: the bus write wins and the tick's increment is lost.
- A STATUS W1C in the same cycle as a new match: the set wins and MATCH stays 1.
- A write to COMPARE takes effect on the next cycle; the current cycle compares against the old value.

Interrupt:
- irq_o = MATCH & IRQ_EN, driven from flops with no combinational path from bus inputs.
- Clearing IRQ_EN masks irq_o without clearing MATCH.

Test Plan:
- Reset, then read all 5 registers -> each acks after 1 cycle with data 0; irq_o = 0; err never asserted.
- Write CTRL = 0x1, PRESCALE = 3, COUNT = 0; wait 40 cycles -> COUNT reads 10 (±1 depending on the read cycle); ticks are exactly 4 cycles apart.
- COMPARE = 5, CTRL = 0x7, PRESCALE = 0 -> MATCH and irq_o rise on the tick where COUNT == 5, and the next COUNT is 0. W1C of STATUS = 1 -> irq_o falls the next cycle. A W1C in the same cycle as a match leaves irq_o at 1.
- COUNT = 0xFFFFFFFE, COMPARE = 0, AUTO_RELOAD = 0, EN = 1, PRESCALE = 0 -> COUNT goes 0xFFFFFFFF, then 0 with no match, then a match at 0 on the next tick.
- Write 0xAABBCCDD to COMPARE with sel = 4'b0101 over an initial 0 -> reads 0x00BB00DD. Access to offset 0x18 -> wb_err_o pulses for 1 cycle, no ack, no state change. stb held high for 6 cycles -> exactly 3 ack pulses.
- Assert rstn_i low on the cycle after a request, before its ack -> no ack is seen; all registers read 0 after reset is released. The tag value 1 on a read returns wb_tgd_o = 1 with the ack.
